// File: rtl/audio_pkg.sv
// Shared audio definitions: default serializer geometry and the stereo
// sample pair carried from the sample source to the I2S transmitter.
package audio_pkg;

   // Default serializer geometry
   localparam int AUDIO_MCLK_DIV   = 8;   // system clocks per MCLK period
   localparam int AUDIO_BCLK_RATIO = 4;   // MCLK periods per BCLK period
   localparam int AUDIO_SAMPLE_W   = 24;  // sample width in bits
   localparam int AUDIO_SLOT_W     = 32;  // BCLKs per channel slot

   // One stereo sample pair, two's complement, captured together
   typedef struct packed {
      logic [AUDIO_SAMPLE_W-1:0] left;
      logic [AUDIO_SAMPLE_W-1:0] right;
   } stereo_pair_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S clock generator: owns the BCLK phase counter and derives MCLK, BCLK
// and a one-cycle strobe marking each BCLK falling edge. While en_i is low
// the phase is parked at zero and both clocks are held low.
module i2s_clk_gen
   import audio_pkg::*;
#(
   parameter int MCLK_DIV   = AUDIO_MCLK_DIV,
   parameter int BCLK_RATIO = AUDIO_BCLK_RATIO
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic mclk_o,
   output logic bclk_o,
   output logic bclk_fall_o
);

   localparam int            P      = MCLK_DIV * BCLK_RATIO;
   localparam int            PW     = (P > 1) ? $clog2(P) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(P - 1);

   logic [PW-1:0] p_q;
   logic [PW-1:0] p_d;
   logic          mclk_q;
   logic          mclk_d;
   logic          bclk_q;
   logic          bclk_d;
   logic          wrap_s;

   assign wrap_s      = (p_q == P_LAST);
   // The falling edge of BCLK is the cycle in which the phase wraps to zero
   assign bclk_fall_o = en_i & wrap_s;
   assign mclk_o      = mclk_q;
   assign bclk_o      = bclk_q;

   // Next phase, plus the clock levels that the next phase implies so the
   // registered clocks line up exactly with the phase register
   always_comb begin
      p_d    = p_q;
      mclk_d = 1'b0;
      bclk_d = 1'b0;
      if (en_i) begin
         if (wrap_s) begin
            p_d = '0;
         end else begin
            p_d = p_q + PW'(1);
         end
         mclk_d = ((int'(p_d) % MCLK_DIV) >= (MCLK_DIV / 2));
         bclk_d = (int'(p_d) >= (P / 2));
      end else begin
         p_d = '0;
      end
   end

   // Phase counter and glitch-free registered clock outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p_q    <= '0;
         mclk_q <= 1'b0;
         bclk_q <= 1'b0;
      end else begin
         p_q    <= p_d;
         mclk_q <= mclk_d;
         bclk_q <= bclk_d;
      end
   end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Stereo I2S transmitter. Accepts left/right pairs through a valid/ready
// stream into a one-entry holding register, loads a frame-wide shift
// register at every frame boundary and shifts it out MSB first with
// standard I2S timing (LRCLK leads each slot's MSB by one BCLK). A frame
// boundary with nothing held sends silence and pulses underrun.
// Optional build macro: I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun_cnt output.
module i2s_tx_serializer
   import audio_pkg::*;
#(
   parameter int MCLK_DIV   = AUDIO_MCLK_DIV,
   parameter int BCLK_RATIO = AUDIO_BCLK_RATIO,
   parameter int SAMPLE_W   = AUDIO_SAMPLE_W,
   parameter int SLOT_W     = AUDIO_SLOT_W
) (
   input  logic                clk1000,
   input  logic                cpu_reset0,
   input  logic                en,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SAMPLE_W-1:0] s_left,
   input  logic [SAMPLE_W-1:0] s_right,
   output logic                i2s_tx_mclk,
   output logic                i2s_tx_clk,
   output logic                i2s_tx_sync,
   output logic                i2s_tx_tx,
`ifdef I2S_TX_UNDERRUN_CNT_EN
   output logic [15:0]         underrun_cnt,
`endif
   output logic                underrun
);

   localparam int            FRAME_W = 2 * SLOT_W;
   localparam int            BW      = $clog2(FRAME_W);
   localparam logic [BW-1:0] B_LAST  = BW'(FRAME_W - 1);

   // Place each sample left-justified in its slot, zero padded below
   function automatic logic [FRAME_W-1:0] pack_frame(input stereo_pair_t pair);
      logic [FRAME_W-1:0] frame;
      frame                        = '0;
      frame[FRAME_W-1 -: SAMPLE_W] = pair.left;
      frame[SLOT_W-1 -: SAMPLE_W]  = pair.right;
      return frame;
   endfunction

   // LRCLK is high from the last bit of the left slot to the second-last
   // bit of the right slot, so it changes one BCLK ahead of each MSB
   function automatic logic in_right_slot(input logic [BW-1:0] b);
      return (int'(b) >= (SLOT_W - 1)) && (int'(b) <= (FRAME_W - 2));
   endfunction

   logic               bclk_fall_s;
   logic               load_s;
   logic               accept_s;
   stereo_pair_t       pair_s;

   logic [BW-1:0]      b_q;
   logic [BW-1:0]      b_d;
   logic [FRAME_W-1:0] shift_q;
   logic [FRAME_W-1:0] shift_d;
   stereo_pair_t       hold_q;
   stereo_pair_t       hold_d;
   logic               hold_full_q;
   logic               hold_full_d;
   logic               s_ready_q;
   logic               s_ready_d;
   logic               tx_q;
   logic               tx_d;
   logic               sync_q;
   logic               sync_d;
   logic               underrun_q;
   logic               underrun_d;

   i2s_clk_gen #(
      .MCLK_DIV   (MCLK_DIV),
      .BCLK_RATIO (BCLK_RATIO)
   ) u_clk_gen (
      .clk_i       (clk1000),
      .rst_ni      (cpu_reset0),
      .en_i        (en),
      .mclk_o      (i2s_tx_mclk),
      .bclk_o      (i2s_tx_clk),
      .bclk_fall_o (bclk_fall_s)
   );

   assign pair_s   = {s_left, s_right};
   // Ready comes straight from the holding-register state, never from s_valid
   assign accept_s = s_valid & s_ready_q;
   assign load_s   = bclk_fall_s & (b_q == B_LAST);

   assign s_ready     = s_ready_q;
   assign i2s_tx_tx   = tx_q;
   assign i2s_tx_sync = sync_q;
   assign underrun    = underrun_q;

   // Bit counter, shift register, holding register and registered outputs
   always_comb begin
      b_d         = b_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      underrun_d  = 1'b0;

      if (!en) begin
         b_d     = B_LAST;
         shift_d = '0;
      end else if (bclk_fall_s) begin
         if (load_s) begin
            b_d = '0;
            if (hold_full_q) begin
               shift_d     = pack_frame(hold_q);
               hold_full_d = 1'b0;
            end else begin
               shift_d    = '0;
               underrun_d = 1'b1;
            end
         end else begin
            b_d     = b_q + BW'(1);
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
         end
      end else begin
         b_d     = b_q;
         shift_d = shift_q;
      end

      // A pair accepted on the load edge is kept for the next frame; the
      // load above already decided from the old (empty) state
      if (accept_s) begin
         hold_d      = pair_s;
         hold_full_d = 1'b1;
      end else begin
         hold_d = hold_q;
      end

      s_ready_d = ~hold_full_d;
      tx_d      = en & shift_d[FRAME_W-1];
      sync_d    = en & in_right_slot(b_d);
   end

   // State and output registers, all cleared by the asynchronous reset
   always_ff @(posedge clk1000 or negedge cpu_reset0) begin
      if (!cpu_reset0) begin
         b_q         <= B_LAST;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         s_ready_q   <= 1'b1;
         tx_q        <= 1'b0;
         sync_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         b_q         <= b_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         s_ready_q   <= s_ready_d;
         tx_q        <= tx_d;
         sync_q      <= sync_d;
         underrun_q  <= underrun_d;
      end
   end

`ifdef I2S_TX_UNDERRUN_CNT_EN
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   assign underrun_cnt = cnt_q;

   // Saturating underrun counter, stepping together with the underrun pulse
   always_comb begin
      if (underrun_d && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Underrun counter register, cleared only by reset
   always_ff @(posedge clk1000 or negedge cpu_reset0) begin
      if (!cpu_reset0) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer (default parameters).
// A frame-level reference model predicts every output each cycle from the
// number of enabled cycles since en rose; fixed vectors check exact slot
// words, and hand-written sequences cover clock ratios, starvation,
// back-pressure and reset in mid-frame.
module tb_i2s_tx_serializer;

   logic        clk1000    = 1'b0;
   logic        cpu_reset0 = 1'b0;
   logic        en         = 1'b0;
   logic        s_valid    = 1'b0;
   logic [23:0] s_left     = 24'h0;
   logic [23:0] s_right    = 24'h0;
   logic        s_ready;
   logic        i2s_tx_mclk;
   logic        i2s_tx_clk;
   logic        i2s_tx_sync;
   logic        i2s_tx_tx;
   logic        underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
`endif

   int tests = 0;
   int fails = 0;

   // Reference model: t_m = enabled clock edges since en rose
   int unsigned t_m;
   bit          en_m;
   bit          pend_m;
   logic [23:0] pl_m;
   logic [23:0] pr_m;
   logic [63:0] frame_m;
   bit          ur_m;
   int unsigned cnt_m;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      logic [31:0] exp_l;
      logic [31:0] exp_r;
   } vec_t;
   vec_t vecs[4];

   always #5ns clk1000 = ~clk1000;

   i2s_tx_serializer dut (
      .clk1000      (clk1000),
      .cpu_reset0   (cpu_reset0),
      .en           (en),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_left       (s_left),
      .s_right      (s_right),
      .i2s_tx_mclk  (i2s_tx_mclk),
      .i2s_tx_clk   (i2s_tx_clk),
      .i2s_tx_sync  (i2s_tx_sync),
      .i2s_tx_tx    (i2s_tx_tx),
`ifdef I2S_TX_UNDERRUN_CNT_EN
      .underrun_cnt (underrun_cnt),
`endif
      .underrun     (underrun)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      t_m     = 0;
      en_m    = 1'b0;
      pend_m  = 1'b0;
      pl_m    = 24'h0;
      pr_m    = 24'h0;
      frame_m = 64'h0;
      ur_m    = 1'b0;
      cnt_m   = 0;
   endtask

   // Advance the model across one clock edge using the inputs now applied
   task automatic model_edge();
      bit pend_pre;
      ur_m = 1'b0;
      if (!cpu_reset0) begin
         model_reset();
         return;
      end
      pend_pre = pend_m;
      if (!en) begin
         t_m     = 0;
         frame_m = 64'h0;
      end else begin
         t_m++;
         // Frame boundaries: first at 32 enabled cycles, then every 2048
         if (t_m >= 32 && ((t_m - 32) % 2048) == 0) begin
            if (pend_m) begin
               frame_m = {pl_m, 8'h00, pr_m, 8'h00};
               pend_m  = 1'b0;
            end else begin
               frame_m = 64'h0;
               ur_m    = 1'b1;
               if (cnt_m < 65535) cnt_m++;
            end
         end
      end
      if (s_valid && !pend_pre) begin
         pend_m = 1'b1;
         pl_m   = s_left;
         pr_m   = s_right;
      end
      en_m = en;
   endtask

   // Compare all outputs against the model's view of the current cycle
   task automatic check_cycle();
      logic [5:0]  exp;
      logic [5:0]  act;
      int unsigned ph;
      int unsigned f;
      int unsigned b;
      exp    = 6'b0;
      exp[1] = !pend_m;
      exp[0] = ur_m;
      if (en_m) begin
         ph     = t_m % 32;
         exp[5] = ((ph % 8) >= 4);
         exp[4] = (ph >= 16);
         f      = t_m / 32;
         if (f > 0) begin
            b      = (f - 1) % 64;
            exp[3] = (b >= 31 && b <= 62);
            exp[2] = frame_m[63 - b];
         end
      end
      act = {i2s_tx_mclk, i2s_tx_clk, i2s_tx_sync, i2s_tx_tx, s_ready, underrun};
      check("cycle {mclk,bclk,sync,tx,ready,underrun}", 64'(act), 64'(exp));
`ifdef I2S_TX_UNDERRUN_CNT_EN
      check("underrun_cnt", 64'(underrun_cnt), 64'(cnt_m));
`endif
   endtask

   task automatic step();
      @(posedge clk1000);
      model_edge();
      #1ns;
      check_cycle();
   endtask

   task automatic apply_reset();
      cpu_reset0 = 1'b0;
      en         = 1'b0;
      s_valid    = 1'b0;
      model_reset();
      #25ns;
      cpu_reset0 = 1'b1;
   endtask

   initial begin
      logic [63:0] cap_tx;
      logic [63:0] cap_sync;
      int          n_mr, n_br, n_sr, n_mh, n_bh, n_sh, n_txh, n_ur, n_acc;
      logic        pm, pb, ps;

      vecs[0] = '{l: 24'hABCDEF, r: 24'h123456, exp_l: 32'hABCDEF00, exp_r: 32'h12345600};
      vecs[1] = '{l: 24'h800000, r: 24'h7FFFFF, exp_l: 32'h80000000, exp_r: 32'h7FFFFF00};
      vecs[2] = '{l: 24'h000000, r: 24'hFFFFFF, exp_l: 32'h00000000, exp_r: 32'hFFFFFF00};
      vecs[3] = '{l: 24'h000001, r: 24'h800001, exp_l: 32'h00000100, exp_r: 32'h80000100};

      // Power-on reset held for 200 ns, released with en low
      model_reset();
      #200ns;
      cpu_reset0 = 1'b1;
      #1ns;
      check("reset_bus", 64'({i2s_tx_mclk, i2s_tx_clk, i2s_tx_sync, i2s_tx_tx}), 64'h0);
      check("reset_ready", 64'(s_ready), 64'h1);
      check("reset_underrun", 64'(underrun), 64'h0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
      check("reset_underrun_cnt", 64'(underrun_cnt), 64'h0);
`endif

      // Fixed vectors: exact slot contents and LRCLK pattern of one frame
      for (int vi = 0; vi < 4; vi++) begin
         apply_reset();
         s_left  = vecs[vi].l;
         s_right = vecs[vi].r;
         s_valid = 1'b1;
         step();
         s_valid = 1'b0;
         check("ready_low_when_held", 64'(s_ready), 64'h0);
         en = 1'b1;
         for (int i = 0; i < 31; i++) step();
         check("tx_before_first_msb", 64'(i2s_tx_tx), 64'h0);
         step();
         check("first_msb_at_32", 64'(i2s_tx_tx), 64'(vecs[vi].exp_l[31]));
         for (int j = 0; j < 64; j++) begin
            cap_tx[63 - j]   = i2s_tx_tx;
            cap_sync[63 - j] = i2s_tx_sync;
            if (j < 63) repeat (32) step();
         end
         check("left_slot_word", 64'(cap_tx[63:32]), 64'(vecs[vi].exp_l));
         check("right_slot_word", 64'(cap_tx[31:0]), 64'(vecs[vi].exp_r));
         check("sync_pattern", cap_sync, 64'h00000001_FFFFFFFE);
         en = 1'b0;
         step();
      end

      // Starvation plus clock ratios over two frame-aligned frames
      apply_reset();
      en = 1'b1;
      for (int i = 0; i < 31; i++) step();
      pm = i2s_tx_mclk; pb = i2s_tx_clk; ps = i2s_tx_sync;
      n_mr = 0; n_br = 0; n_sr = 0; n_mh = 0; n_bh = 0; n_sh = 0; n_txh = 0; n_ur = 0;
      for (int i = 0; i < 4096; i++) begin
         step();
         if (i2s_tx_mclk && !pm) n_mr++;
         if (i2s_tx_clk && !pb) n_br++;
         if (i2s_tx_sync && !ps) n_sr++;
         if (i2s_tx_mclk) n_mh++;
         if (i2s_tx_clk) n_bh++;
         if (i2s_tx_sync) n_sh++;
         if (i2s_tx_tx) n_txh++;
         if (underrun) n_ur++;
         pm = i2s_tx_mclk; pb = i2s_tx_clk; ps = i2s_tx_sync;
      end
      check("mclk_rises", 64'(n_mr), 64'd512);
      check("bclk_rises", 64'(n_br), 64'd128);
      check("sync_rises", 64'(n_sr), 64'd2);
      check("mclk_high", 64'(n_mh), 64'd2048);
      check("bclk_high", 64'(n_bh), 64'd2048);
      check("sync_high", 64'(n_sh), 64'd2048);
      check("starved_tx_high", 64'(n_txh), 64'd0);
      check("starved_underruns", 64'(n_ur), 64'd2);
`ifdef I2S_TX_UNDERRUN_CNT_EN
      check("starved_underrun_cnt", 64'(underrun_cnt), 64'd2);
`endif

      // Back-pressure: valid held high with data changing every cycle
      apply_reset();
      s_valid = 1'b1;
      en      = 1'b1;
      n_acc = 0; n_ur = 0;
      for (int i = 0; i < 4128; i++) begin
         s_left  = 24'($urandom);
         s_right = 24'($urandom);
         if (s_ready && s_valid) n_acc++;
         step();
         if (underrun) n_ur++;
      end
      check("backpressure_accepts", 64'(n_acc), 64'd3);
      check("backpressure_underruns", 64'(n_ur), 64'd0);
      s_valid = 1'b0;

      // Reset in mid-frame at b=20 with a pair still waiting
      apply_reset();
      s_left = 24'h5A5A5A; s_right = 24'hA5A5A5; s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      en = 1'b1;
      for (int i = 0; i < 40; i++) step();
      s_left = 24'hC0FFEE; s_right = 24'h0BADF0; s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      while (t_m < 32 + 20 * 32) step();
      #3ns;
      cpu_reset0 = 1'b0;
      model_reset();
      #1ns;
      check("midreset_bus", 64'({i2s_tx_mclk, i2s_tx_clk, i2s_tx_sync, i2s_tx_tx, underrun}), 64'h0);
      check("midreset_ready", 64'(s_ready), 64'h1);
      @(posedge clk1000);
      #1ns;
      cpu_reset0 = 1'b1;
      for (int i = 0; i < 32; i++) step();
      check("post_reset_underrun", 64'(underrun), 64'h1);
      check("post_reset_tx", 64'(i2s_tx_tx), 64'h0);
      step();

      // Randomised traffic with occasional enable toggles
      apply_reset();
      en = 1'b1;
      for (int i = 0; i < 16000; i++) begin
         s_valid = ($urandom_range(0, 5) == 0);
         s_left  = 24'($urandom);
         s_right = 24'($urandom);
         if ($urandom_range(0, 2999) == 0) en = ~en;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Stereo I2S transmitter that converts parallel left/right sample pairs into the serial audio bus driven off-chip as `i2s_tx0_clk`, `i2s_tx0_sync`, `i2s_tx0_tx` and `i2s_tx_mclk0`. It is the last stage before the pins: the audio sample source feeds it through a valid/ready stream, and it derives MCLK, BCLK and LRCLK from the 100 MHz system clock. A one-entry holding register decouples the source from frame timing. Frames with no sample available are filled with silence and flagged as underruns.

## Interface
- `MCLK_DIV`, 8: system clocks per MCLK period. Even, ≥2.
- `BCLK_RATIO`, 4: MCLK periods per BCLK period.
- `SAMPLE_W`, 24: sample width in bits. Must be ≤ `SLOT_W`.
- `SLOT_W`, 32: BCLKs per channel slot. A frame is 2·`SLOT_W` BCLKs.
- Derived: P = `MCLK_DIV`·`BCLK_RATIO` = 32 system clocks per BCLK.
- `clk1000`, in, 1: system clock, 100 MHz.
- `cpu_reset0`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: serializer enable.
- `s_valid`, in, 1: sample pair valid.
- `s_ready`, out, 1: holding register empty.
- `s_left`, in, `SAMPLE_W`: left sample, two's complement.
- `s_right`, in, `SAMPLE_W`: right sample, two's complement.
- `i2s_tx_mclk`, out, 1: master clock.
- `i2s_tx_clk`, out, 1: bit clock (BCLK).
- `i2s_tx_sync`, out, 1: LRCLK. 0 = left slot, 1 = right slot.
- `i2s_tx_tx`, out, 1: serial data.
- `underrun`, out, 1: one-cycle pulse when a frame loads with no sample available.

## Operation
- **Phase counter** p:
  - Counts 0..P-1 and wraps.
  - `i2s_tx_mclk` = ((p mod `MCLK_DIV`) ≥ `MCLK_DIV`/2).
  - `i2s_tx_clk` = (p ≥ P/2).
- **BCLK falling edge**: the cycle where p wraps from P-1 to 0.
  - On this edge the bit counter b (0..2·`SLOT_W`-1) increments and wraps.
  - The shift register shifts left by one bit.
- **Frame load**: occurs when b wraps to 0.
  - If the holding register is full, the 64-bit shift register loads {`s_left`, zero pad, `s_right`, zero pad}. Each sample is left-justified, MSB first, in its slot. The holding register is then emptied.
  - If the holding register is empty, the shift register loads all zeros and `underrun` pulses.
- **Outputs**:
  - `i2s_tx_tx` = shift register MSB.
  - `i2s_tx_sync` = 1 for b in [`SLOT_W`-1, 2·`SLOT_W`-2], otherwise 0. This gives standard I2S timing: LRCLK changes one BCLK before each slot's MSB.
- **Handshake**:
  - `s_ready` = holding register empty.
  - A transfer occurs on `s_valid` & `s_ready`. `s_left` and `s_right` are captured together.
  - `s_ready` does not depend on `s_valid`.
- **Accept and load in the same cycle**: when a transfer and a frame load coincide with the holding register empty, the load sees empty (zeros, `underrun`). The new pair is stored for the next frame. There is no bypass path.
- **`en` low**:
  - p, b and the shift register are held at their reset values.
  - All bus outputs are 0.
  - The holding register and handshake stay live.

## Timing
- **Reset values**:
  - p=0, b=2·`SLOT_W`-1, shift register=0, holding register empty.
  - Outputs: `s_ready`=1, all bus outputs 0, `underrun`=0.
- All outputs are registered and glitch-free.
- **Startup**: the first BCLK falling edge, and therefore the first frame load, occurs P cycles after `en` rises. With default parameters this is 32 cycles.
- **Periods and rates** (default parameters):
  - Frame period: 2·`SLOT_W`·P = 2048 cycles.
  - fs = 48.828 kHz.
  - BCLK = 3.125 MHz, MCLK = 12.5 MHz.
- **Sample pacing**: a pair accepted in any cycle before a frame load is transmitted in that frame. Thereafter `s_ready` remains 0 until that load.
- **`underrun` timing**: asserted in the cycle after the load edge, for exactly one cycle.
- **Reset mid-frame**: all state returns to reset values immediately, and the holding register contents are discarded.

## Configuration
- Macro: `I2S_TX_UNDERRUN_CNT_EN`.
- **Defined**:
  - Adds output `underrun_cnt` (16 bits).
  - Increments on each `underrun` pulse and saturates at 0xFFFF.
  - Cleared only by reset.
- **Undefined**: the port and the counter are absent. `underrun` behaviour is unchanged.

## Structure
- **Shared package `audio_pkg`** holds:
  - Default parameter constants (`MCLK_DIV`, `BCLK_RATIO`, `SAMPLE_W`, `SLOT_W`).
  - The stereo sample pair typedef.
- **Sub-module `i2s_clk_gen`**: owns the phase counter and produces `i2s_tx_mclk`, `i2s_tx_clk` and the BCLK-fall strobe.
- **Top level of this block**: holds the bit counter, shift register, holding register and handshake logic.

## Test plan
- **Reset**: hold `cpu_reset0`=0 for 200 ns, then release with `en`=0 → all bus outputs 0, `s_ready`=1, `underrun`=0.
- **Single frame**: write L=0xABCDEF, R=0x123456, then raise `en` → first MSB at cycle 32.
  - Left slot bits = 0xABCDEF00 MSB first, with sync=0.
  - Right slot bits = 0x12345600, with sync=1.
  - Sync rises one BCLK before the right-slot MSB.
- **Clock ratios**: MCLK period 8 cycles, BCLK period 32 cycles, sync period 2048 cycles, all 50% duty.
- **Starvation**: `en`=1 with `s_valid`=0 → tx stays 0 and `underrun` pulses once every 2048 cycles. With the macro defined, `underrun_cnt` increments by one per frame.
- **Back-pressure**: hold `s_valid`=1 continuously → exactly one accept per frame, `s_ready` low between accepts, and no underruns after the first frame.
- **Reset mid-frame**: assert reset at b=20 → outputs return to 0 asynchronously. After release, the pending sample pair is gone and the first frame is an underrun.
